// File: rtl/i2c_sync_slave_if.sv
// Register-side bundle of the I2C target: bus clock, own address and status/memory outputs.
// SDA stays a plain inout on the target because it is an open-drain wire.
interface i2c_sync_slave_if #(
  parameter int ADDR_W = 7,
  parameter int NBYTES = 2
) ();
  logic                  SCL;
  logic [ADDR_W-1:0]     OwnAddress;
  logic [8*NBYTES-1:0]   MemoryData;
  logic [7:0]            RxByte;
  logic                  WriteStrobe;
  logic                  AddressMatch;
  logic                  Busy;
  logic [2:0]            SlaveState;

  modport slave (
    input  SCL,
    input  OwnAddress,
    output MemoryData,
    output RxByte,
    output WriteStrobe,
    output AddressMatch,
    output Busy,
    output SlaveState
  );

  modport master (
    output SCL,
    output OwnAddress,
    input  MemoryData,
    input  RxByte,
    input  WriteStrobe,
    input  AddressMatch,
    input  Busy,
    input  SlaveState
  );
endinterface

// File: rtl/i2c_sync_slave.sv
// Clock-synchronous I2C target with a small byte memory; oversamples SCL/SDA,
// never stretches SCL, and only ever pulls SDA low or releases it.
module i2c_sync_slave #(
  parameter int ADDR_W = 7,
  parameter int NBYTES = 2,
  parameter int PTR_W  = 1
) (
  input  logic             Clk,
  input  logic             Rst,
  inout  wire              SDA,
  i2c_sync_slave_if.slave  bus
);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ADDR      = 3'd1,
    ST_ADDR_ACK  = 3'd2,
    ST_WRITE     = 3'd3,
    ST_WRITE_ACK = 3'd4,
    ST_READ      = 3'd5,
    ST_READ_ACK  = 3'd6,
    ST_WAIT_STOP = 3'd7
  } state_t;

  state_t             state_q, state_d;
  logic [2:0]         scl_sync_q, scl_sync_d;
  logic [2:0]         sda_sync_q, sda_sync_d;
  logic [2:0]         bit_cnt_q, bit_cnt_d;
  logic [7:0]         shift_q, shift_d;
  logic [PTR_W-1:0]   ptr_q, ptr_d;
  logic [7:0]         mem_q [NBYTES];
  logic [7:0]         mem_d [NBYTES];
  logic [7:0]         rx_byte_q, rx_byte_d;
  logic               wstrobe_q, wstrobe_d;
  logic               match_q, match_d;
  logic               busy_q, busy_d;
  logic               rw_q, rw_d;
  logic               sda_oe_q, sda_oe_d;
  logic               phase_q, phase_d;

  logic               scl_now_s, scl_prev_s, sda_now_s, sda_prev_s;
  logic               scl_rise_s, scl_fall_s, start_s, stop_s;
  logic [7:0]         in_byte_s;
  logic [8*NBYTES-1:0] mem_flat_s;

  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(NBYTES - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign SDA = sda_oe_q ? 1'b0 : 1'bz;

  assign scl_now_s  = scl_sync_q[1];
  assign scl_prev_s = scl_sync_q[2];
  assign sda_now_s  = sda_sync_q[1];
  assign sda_prev_s = sda_sync_q[2];
  assign scl_rise_s = scl_now_s & ~scl_prev_s;
  assign scl_fall_s = ~scl_now_s & scl_prev_s;
  // SCL must be high on both samples so an SDA change near an SCL edge is not a START/STOP
  assign start_s    = scl_now_s & scl_prev_s & ~sda_now_s & sda_prev_s;
  assign stop_s     = scl_now_s & scl_prev_s & sda_now_s & ~sda_prev_s;
  assign in_byte_s  = {shift_q[6:0], sda_now_s};

  always_comb begin
    mem_flat_s = '0;
    for (int k = 0; k < NBYTES; k++) begin
      mem_flat_s[8*k +: 8] = mem_q[k];
    end
  end

  assign bus.MemoryData   = mem_flat_s;
  assign bus.RxByte       = rx_byte_q;
  assign bus.WriteStrobe  = wstrobe_q;
  assign bus.AddressMatch = match_q;
  assign bus.Busy         = busy_q;
  assign bus.SlaveState   = state_q;

  always_comb begin
    scl_sync_d = {scl_sync_q[1:0], bus.SCL};
    sda_sync_d = {sda_sync_q[1:0], SDA};
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    ptr_d      = ptr_q;
    mem_d      = mem_q;
    rx_byte_d  = rx_byte_q;
    wstrobe_d  = 1'b0;
    match_d    = match_q;
    busy_d     = busy_q;
    rw_d       = rw_q;
    sda_oe_d   = sda_oe_q;
    phase_d    = phase_q;

    if (start_s) begin
      state_d   = ST_ADDR;
      bit_cnt_d = 3'd0;
      ptr_d     = '0;
      match_d   = 1'b0;
      busy_d    = 1'b1;
      sda_oe_d  = 1'b0;
      phase_d   = 1'b0;
    end else if (stop_s) begin
      state_d   = ST_IDLE;
      bit_cnt_d = 3'd0;
      match_d   = 1'b0;
      busy_d    = 1'b0;
      sda_oe_d  = 1'b0;
      phase_d   = 1'b0;
    end else begin
      case (state_q)
        ST_ADDR: begin
          if (scl_rise_s) begin
            shift_d   = in_byte_s;
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              if (in_byte_s[ADDR_W:1] == bus.OwnAddress) begin
                rw_d    = in_byte_s[0];
                match_d = 1'b1;
                phase_d = 1'b0;
                state_d = ST_ADDR_ACK;
              end else begin
                state_d = ST_WAIT_STOP;
              end
            end
          end
        end
        // phase 0: waiting for the fall that starts the ACK slot; phase 1: ACK driven
        ST_ADDR_ACK, ST_WRITE_ACK: begin
          if (scl_fall_s) begin
            if (!phase_q) begin
              sda_oe_d = 1'b1;
              phase_d  = 1'b1;
            end else begin
              phase_d   = 1'b0;
              bit_cnt_d = 3'd0;
              if ((state_q == ST_WRITE_ACK) || !rw_q) begin
                sda_oe_d = 1'b0;
                state_d  = ST_WRITE;
              end else begin
                shift_d  = mem_q[ptr_q];
                sda_oe_d = ~mem_q[ptr_q][7];
                state_d  = ST_READ;
              end
            end
          end
        end
        ST_WRITE: begin
          if (scl_rise_s) begin
            shift_d   = in_byte_s;
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              mem_d[ptr_q] = in_byte_s;
              rx_byte_d    = in_byte_s;
              wstrobe_d    = 1'b1;
              ptr_d        = ptr_next(ptr_q);
              phase_d      = 1'b0;
              state_d      = ST_WRITE_ACK;
            end
          end
        end
        ST_READ: begin
          if (scl_fall_s) begin
            if (bit_cnt_q == 3'd7) begin
              sda_oe_d = 1'b0;
              phase_d  = 1'b0;
              state_d  = ST_READ_ACK;
            end else begin
              shift_d   = {shift_q[6:0], 1'b0};
              sda_oe_d  = ~shift_q[6];
              bit_cnt_d = bit_cnt_q + 3'd1;
            end
          end
        end
        // phase 1 means the master ACKed and the next byte goes out on the coming fall
        ST_READ_ACK: begin
          if (scl_rise_s && !phase_q) begin
            if (!sda_now_s) begin
              ptr_d   = ptr_next(ptr_q);
              phase_d = 1'b1;
            end else begin
              state_d = ST_WAIT_STOP;
            end
          end else if (scl_fall_s && phase_q) begin
            shift_d   = mem_q[ptr_q];
            sda_oe_d  = ~mem_q[ptr_q][7];
            bit_cnt_d = 3'd0;
            phase_d   = 1'b0;
            state_d   = ST_READ;
          end else begin
            phase_d = phase_q;
          end
        end
        ST_IDLE, ST_WAIT_STOP: begin
          sda_oe_d = 1'b0;
        end
        default: begin
          state_d  = ST_IDLE;
          sda_oe_d = 1'b0;
        end
      endcase
    end
  end

  // Synchronizers reset to the idle-bus level so reset release never fakes a START/STOP
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      scl_sync_q <= 3'b111;
      sda_sync_q <= 3'b111;
      state_q    <= ST_IDLE;
      bit_cnt_q  <= 3'd0;
      shift_q    <= 8'h00;
      ptr_q      <= '0;
      for (int k = 0; k < NBYTES; k++) begin
        mem_q[k] <= 8'h00;
      end
      rx_byte_q  <= 8'h00;
      wstrobe_q  <= 1'b0;
      match_q    <= 1'b0;
      busy_q     <= 1'b0;
      rw_q       <= 1'b0;
      sda_oe_q   <= 1'b0;
      phase_q    <= 1'b0;
    end else begin
      scl_sync_q <= scl_sync_d;
      sda_sync_q <= sda_sync_d;
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      ptr_q      <= ptr_d;
      mem_q      <= mem_d;
      rx_byte_q  <= rx_byte_d;
      wstrobe_q  <= wstrobe_d;
      match_q    <= match_d;
      busy_q     <= busy_d;
      rw_q       <= rw_d;
      sda_oe_q   <= sda_oe_d;
      phase_q    <= phase_d;
    end
  end

endmodule

// File: tb/tb_i2c_sync_slave.sv
// Bench for i2c_sync_slave: bit-level I2C master, array/queue reference model,
// and a write scoreboard drained by a monitor on WriteStrobe.
`timescale 1ns/1ps
module tb_i2c_sync_slave;
  localparam int NB  = 2;
  localparam int Q   = 8;
  localparam logic [6:0] OWN = 7'h55;

  logic clk;
  logic rst;
  logic m_sda_low;
  wire  SDA;

  i2c_sync_slave_if #(.ADDR_W(7), .NBYTES(NB)) bus ();

  i2c_sync_slave #(.ADDR_W(7), .NBYTES(NB), .PTR_W(1)) dut (
    .Clk (clk),
    .Rst (rst),
    .SDA (SDA),
    .bus (bus)
  );

  assign SDA = m_sda_low ? 1'b0 : 1'bz;
  pullup (SDA);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0]  rx;
    logic [15:0] mem;
  } exp_t;

  exp_t       exp_q [$];
  exp_t       mon_e;
  logic [7:0] model_mem [NB];
  int         mptr;
  int         checks = 0;
  int         errors = 0;
  logic [7:0] wd [4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] model_image();
    logic [15:0] r;
    r = '0;
    for (int k = 0; k < NB; k++) r[8*k +: 8] = model_mem[k];
    return r;
  endfunction

  // Monitor: every WriteStrobe must match the next expected write
  always @(negedge clk) begin
    if (!rst && bus.WriteStrobe) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_strobe actual RxByte %0h expected no write", bus.RxByte);
      end else begin
        mon_e = exp_q.pop_front();
        chk("rx_byte", {24'h0, bus.RxByte}, {24'h0, mon_e.rx});
        chk("mem_image", {16'h0, bus.MemoryData}, {16'h0, mon_e.mem});
      end
    end
  end

  task automatic wq(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic i2c_start();
    m_sda_low = 1'b0; wq(Q);
    bus.SCL   = 1'b1; wq(Q);
    m_sda_low = 1'b1; wq(Q);
    bus.SCL   = 1'b0; wq(Q);
    mptr = 0;
  endtask

  task automatic i2c_stop();
    m_sda_low = 1'b1; wq(Q);
    bus.SCL   = 1'b1; wq(Q);
    m_sda_low = 1'b0; wq(Q);
  endtask

  task automatic send_bit(input bit b);
    m_sda_low = ~b; wq(Q);
    bus.SCL = 1'b1; wq(2*Q);
    bus.SCL = 1'b0; wq(Q);
  endtask

  task automatic recv_bit(output bit b);
    m_sda_low = 1'b0; wq(Q);
    bus.SCL = 1'b1; wq(Q);
    b = (SDA === 1'b0) ? 1'b0 : 1'b1;
    wq(Q);
    bus.SCL = 1'b0; wq(Q);
  endtask

  task automatic write_byte(input logic [7:0] b, output bit nack);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
    recv_bit(nack);
  endtask

  task automatic read_byte(output logic [7:0] b, input bit ack);
    bit x;
    for (int i = 7; i >= 0; i--) begin
      recv_bit(x);
      b[i] = x;
    end
    send_bit(~ack);
  endtask

  task automatic model_write(input logic [7:0] b);
    exp_t e;
    model_mem[mptr] = b;
    mptr = (mptr + 1) % NB;
    e.rx  = b;
    e.mem = model_image();
    exp_q.push_back(e);
  endtask

  task automatic txn(input logic [6:0] a, input bit rw, input int n, input bit use_wd);
    bit nack;
    bit match;
    logic [7:0] b;
    logic [7:0] e;
    i2c_start();
    match = (a == OWN);
    write_byte({a, rw}, nack);
    chk("addr_ack", {31'h0, nack}, {31'h0, ~match});
    chk("addr_match", {31'h0, bus.AddressMatch}, {31'h0, match});
    chk("busy_in_txn", {31'h0, bus.Busy}, 32'h1);
    if (!match) begin
      chk("state_wait_stop", {29'h0, bus.SlaveState}, 32'h7);
    end else begin
      chk("state_after_addr", {29'h0, bus.SlaveState}, rw ? 32'h5 : 32'h3);
      for (int i = 0; i < n; i++) begin
        if (!rw) begin
          b = use_wd ? wd[i] : 8'($urandom);
          model_write(b);
          write_byte(b, nack);
          chk("data_ack", {31'h0, nack}, 32'h0);
        end else begin
          e = model_mem[mptr];
          read_byte(b, i != n - 1);
          chk("read_data", {24'h0, b}, {24'h0, e});
          if (i != n - 1) mptr = (mptr + 1) % NB;
        end
      end
      if (rw) chk("state_after_nack", {29'h0, bus.SlaveState}, 32'h7);
    end
    i2c_stop();
    chk("state_idle", {29'h0, bus.SlaveState}, 32'h0);
    chk("busy_idle", {31'h0, bus.Busy}, 32'h0);
    chk("match_idle", {31'h0, bus.AddressMatch}, 32'h0);
    chk("mem_after_txn", {16'h0, bus.MemoryData}, {16'h0, model_image()});
  endtask

  initial begin
    bit nack;
    logic [6:0] a;
    rst = 1'b1;
    m_sda_low = 1'b0;
    bus.SCL = 1'b1;
    bus.OwnAddress = OWN;
    mptr = 0;
    for (int k = 0; k < NB; k++) model_mem[k] = 8'h00;
    wq(3);
    rst = 1'b0;
    wq(10);
    chk("reset_state", {29'h0, bus.SlaveState}, 32'h0);
    chk("reset_busy", {31'h0, bus.Busy}, 32'h0);
    chk("reset_sda", {31'h0, SDA}, 32'h1);
    chk("reset_mem", {16'h0, bus.MemoryData}, 32'h0);
    chk("reset_rx", {24'h0, bus.RxByte}, 32'h0);
    chk("reset_match", {31'h0, bus.AddressMatch}, 32'h0);

    txn(7'h56, 1'b0, 0, 1'b0);

    wd[0] = 8'hF0; wd[1] = 8'hAA;
    txn(OWN, 1'b0, 2, 1'b1);
    chk("mem_f0aa", {16'h0, bus.MemoryData}, 32'hAAF0);
    chk("rx_aa", {24'h0, bus.RxByte}, 32'hAA);

    txn(OWN, 1'b1, 2, 1'b0);

    wd[0] = 8'h11; wd[1] = 8'h22; wd[2] = 8'h33;
    txn(OWN, 1'b0, 3, 1'b1);
    chk("mem_wrap", {16'h0, bus.MemoryData}, 32'h2233);

    // STOP after four data bits: partial byte must be dropped
    i2c_start();
    write_byte({OWN, 1'b0}, nack);
    chk("partial_addr_ack", {31'h0, nack}, 32'h0);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    i2c_stop();
    chk("partial_state", {29'h0, bus.SlaveState}, 32'h0);
    chk("partial_mem", {16'h0, bus.MemoryData}, {16'h0, model_image()});

    // Reset while the target is driving the address ACK
    i2c_start();
    for (int i = 7; i >= 0; i--) send_bit(i == 0 ? 1'b0 : OWN[i-1]);
    m_sda_low = 1'b0; wq(Q);
    bus.SCL = 1'b1; wq(Q);
    chk("ack_driven", {31'h0, SDA}, 32'h0);
    rst = 1'b1;
    #1;
    chk("rst_sda_release", {31'h0, SDA}, 32'h1);
    chk("rst_state", {29'h0, bus.SlaveState}, 32'h0);
    for (int k = 0; k < NB; k++) model_mem[k] = 8'h00;
    wq(2);
    rst = 1'b0;
    wq(2);
    bus.SCL = 1'b0; wq(Q);
    i2c_stop();
    chk("rst_idle", {29'h0, bus.SlaveState}, 32'h0);
    chk("rst_mem", {16'h0, bus.MemoryData}, {16'h0, model_image()});

    for (int t = 0; t < 20; t++) begin
      a = OWN;
      if ($urandom_range(0, 3) == 0) begin
        a = 7'($urandom);
        if (a == OWN) a = a ^ 7'h01;
      end
      txn(a, 1'($urandom_range(0, 1)), int'($urandom_range(1, 4)), 1'b0);
    end

    for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(posedge clk);
    chk("scoreboard_drain", exp_q.size(), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
